// File: rtl/serial_subtractor_pkg.sv
// Shared types for the digit-serial subtractor.
// State encoding and digit-count helper.
package serial_sub_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } ss_state_e;

  function automatic int ndig(input int width, input int digit);
    return width / digit;
  endfunction

endpackage

// File: rtl/serial_subtractor_if.sv
// Operand/result handshake bundle for serial_subtractor.
// zero/ovf exist only when SERIAL_SUB_FLAGS_EN is defined.
interface serial_subtractor_if #(
  parameter int WIDTH = 32
);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             bin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] diff;
  logic             bout;
`ifdef SERIAL_SUB_FLAGS_EN
  logic             zero;
  logic             ovf;

  modport master (
    output in_valid, a, b, bin, out_ready,
    input  in_ready, out_valid, diff, bout,
    input  zero, ovf
  );

  modport slave (
    input  in_valid, a, b, bin, out_ready,
    output in_ready, out_valid, diff, bout,
    output zero, ovf
  );
`else
  modport master (
    output in_valid, a, b, bin, out_ready,
    input  in_ready, out_valid, diff, bout
  );

  modport slave (
    input  in_valid, a, b, bin, out_ready,
    output in_ready, out_valid, diff, bout
  );
`endif

endinterface

// File: rtl/serial_subtractor_sub_digit.sv
// One digit of the serial subtractor.
// Combinational ripple-borrow a_d - b_d - bin.
module sub_digit #(
  parameter int DIGIT = 4
) (
  input  logic [DIGIT-1:0] a_d,
  input  logic [DIGIT-1:0] b_d,
  input  logic             bin,
  output logic [DIGIT-1:0] d,
  output logic             bout
);

  logic [DIGIT:0] brw;

  // bit-by-bit ripple borrow through the digit
  always_comb begin
    brw    = '0;
    d      = '0;
    brw[0] = bin;
    for (int i = 0; i < DIGIT; i++) begin
      d[i]     = a_d[i] ^ b_d[i] ^ brw[i];
      brw[i+1] = (~a_d[i] & b_d[i]) |
                 (~(a_d[i] ^ b_d[i]) & brw[i]);
    end
    bout = brw[DIGIT];
  end

endmodule

// File: rtl/serial_subtractor.sv
// Digit-serial a - b - bin, LSB digit first.
// Define SERIAL_SUB_FLAGS_EN for zero/ovf outputs.
module serial_subtractor
  import serial_sub_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DIGIT = 4
) (
  input logic                clk,
  input logic                rst,
  serial_subtractor_if.slave bus
);

  localparam int NDIG = ndig(WIDTH, DIGIT);
  localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam logic [CW-1:0] LAST = CW'(NDIG - 1);

  if ((DIGIT < 1) || (DIGIT > WIDTH) ||
      ((WIDTH % DIGIT) != 0)) begin : g_bad_cfg
    $fatal(1, "serial_subtractor: WIDTH must be a multiple of DIGIT");
  end

  ss_state_e        state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             brw_q, brw_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             bout_q, bout_d;
`ifdef SERIAL_SUB_FLAGS_EN
  logic             am_q, am_d;
  logic             bm_q, bm_d;
  logic             zero_q, zero_d;
  logic             ovf_q, ovf_d;
`endif

  logic [DIGIT-1:0] dig;
  logic             dig_b;
  logic [WIDTH-1:0] res_sh;

  sub_digit #(
    .DIGIT(DIGIT)
  ) u_dig (
    .a_d (a_q[DIGIT-1:0]),
    .b_d (b_q[DIGIT-1:0]),
    .bin (brw_q),
    .d   (dig),
    .bout(dig_b)
  );

  if (DIGIT == WIDTH) begin : g_full
    assign res_sh = dig;
  end else begin : g_part
    assign res_sh = {dig, res_q[WIDTH-1:DIGIT]};
  end

  // next-state, datapath shifts and result capture
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    brw_d   = brw_q;
    res_d   = res_q;
    bout_d  = bout_q;
`ifdef SERIAL_SUB_FLAGS_EN
    am_d    = am_q;
    bm_d    = bm_q;
    zero_d  = zero_q;
    ovf_d   = ovf_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          a_d     = bus.a;
          b_d     = bus.b;
          brw_d   = bus.bin;
          cnt_d   = '0;
          state_d = RUN;
`ifdef SERIAL_SUB_FLAGS_EN
          am_d    = bus.a[WIDTH-1];
          bm_d    = bus.b[WIDTH-1];
`endif
        end
      end
      RUN: begin
        a_d   = a_q >> DIGIT;
        b_d   = b_q >> DIGIT;
        brw_d = dig_b;
        res_d = res_sh;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == LAST) begin
          state_d = DONE;
          bout_d  = dig_b;
`ifdef SERIAL_SUB_FLAGS_EN
          zero_d  = (res_sh == '0);
          ovf_d   = (am_q != bm_q) &&
                    (res_sh[WIDTH-1] != am_q);
`endif
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // state and datapath registers, synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      brw_q   <= 1'b0;
      res_q   <= '0;
      bout_q  <= 1'b0;
`ifdef SERIAL_SUB_FLAGS_EN
      am_q    <= 1'b0;
      bm_q    <= 1'b0;
      zero_q  <= 1'b0;
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      brw_q   <= brw_d;
      res_q   <= res_d;
      bout_q  <= bout_d;
`ifdef SERIAL_SUB_FLAGS_EN
      am_q    <= am_d;
      bm_q    <= bm_d;
      zero_q  <= zero_d;
      ovf_q   <= ovf_d;
`endif
    end
  end

  assign bus.in_ready  = (state_q == IDLE) && !rst;
  assign bus.out_valid = (state_q == DONE);
  assign bus.diff      = res_q;
  assign bus.bout      = bout_q;
`ifdef SERIAL_SUB_FLAGS_EN
  assign bus.zero      = zero_q;
  assign bus.ovf       = ovf_q;
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// Bench for serial_subtractor: directed + random vs a-b-bin model.
// Also runs DIGIT=1 and DIGIT=8 instances back-to-back.
module tb_serial_subtractor;

  localparam int W  = 8;
  localparam int D  = 4;
  localparam int ND = W / D;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  serial_subtractor_if #(.WIDTH(W)) bus ();

  serial_subtractor #(
    .WIDTH(W),
    .DIGIT(D)
  ) u_dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", nm, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #2;
  endtask

  // behavioural model: result is a-b-bin, visible ND edges after accept
  bit         m_busy = 1'b0;
  int         m_age  = 0;
  logic [7:0] m_a, m_b;
  logic [8:0] m_e;
  bit         cmp_en = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      m_busy = 1'b0;
    end else if (m_busy) begin
      if (m_age < ND) m_age++;
      else if (bus.out_ready) m_busy = 1'b0;
    end else if (bus.in_valid) begin
      m_busy = 1'b1;
      m_age  = 0;
      m_a    = bus.a;
      m_b    = bus.b;
      m_e    = {1'b0, bus.a} - {1'b0, bus.b} - 9'(bus.bin);
    end
  end

  // compare process: handshake every cycle, data while valid
  always @(negedge clk) begin
    if (cmp_en) begin
      bit er, ev;
      er = !rst && !m_busy;
      ev = m_busy && (m_age == ND);
      chk("in_ready", 32'(bus.in_ready), 32'(er));
      chk("out_valid", 32'(bus.out_valid), 32'(ev));
      if (ev) begin
        chk("m_diff", 32'(bus.diff), 32'(m_e[7:0]));
        chk("m_bout", 32'(bus.bout), 32'(m_e[8]));
`ifdef SERIAL_SUB_FLAGS_EN
        chk("m_zero", 32'(bus.zero), 32'(m_e[7:0] == 8'h00));
        chk("m_ovf", 32'(bus.ovf),
            32'((m_a[7] != m_b[7]) && (m_e[7] != m_a[7])));
`endif
      end
    end
  end

  task automatic run_op(input logic [7:0] ta, input logic [7:0] tb_,
                        input logic tbin, input logic [7:0] ed,
                        input logic eb, input logic ez, input logic eo);
    int n;
    chk("accept_ready", 32'(bus.in_ready), 32'd1);
    bus.in_valid = 1'b1;
    bus.a        = ta;
    bus.b        = tb_;
    bus.bin      = tbin;
    tick;
    bus.in_valid = 1'b0;
    bus.a        = ~ta;
    bus.b        = 8'($urandom);
    bus.bin      = ~tbin;
    n = 0;
    while (!bus.out_valid && n < 50) begin
      tick;
      n++;
    end
    chk("latency", 32'(n), 32'(ND));
    chk("diff", 32'(bus.diff), 32'(ed));
    chk("bout", 32'(bus.bout), 32'(eb));
`ifdef SERIAL_SUB_FLAGS_EN
    chk("zero", 32'(bus.zero), 32'(ez));
    chk("ovf", 32'(bus.ovf), 32'(eo));
`else
    if (ez || eo) n = 0;
`endif
    tick;
  endtask

  // back-to-back random instances with other digit sizes
  for (genvar g = 0; g < 2; g++) begin : g_bb
    localparam int GD = (g == 0) ? 1 : 8;
    localparam int GN = W / GD;
    logic grst;
    bit   done = 1'b0;
    serial_subtractor_if #(.WIDTH(W)) gb ();

    serial_subtractor #(
      .WIDTH(W),
      .DIGIT(GD)
    ) u_g (
      .clk(clk),
      .rst(grst),
      .bus(gb)
    );

    initial begin
      logic [8:0] q[$];
      logic [8:0] e;
      int got = 0, guard = 0, last = -1;
      bit acc;
      grst = 1'b1;
      gb.in_valid = 1'b0;
      gb.out_ready = 1'b1;
      gb.a = '0;
      gb.b = '0;
      gb.bin = 1'b0;
      tick;
      tick;
      grst = 1'b0;
      gb.in_valid = 1'b1;
      gb.a = 8'($urandom);
      gb.b = 8'($urandom);
      gb.bin = 1'($urandom);
      while (got < 1000 && guard < 20000) begin
        @(negedge clk);
        guard++;
        acc = gb.in_valid && gb.in_ready;
        if (gb.out_valid) begin
          if (q.size() == 0) begin
            chk("bb_spurious", 32'(gb.out_valid), 32'd0);
          end else begin
            e = q.pop_front();
            chk("bb_diff", 32'(gb.diff), 32'(e[7:0]));
            chk("bb_bout", 32'(gb.bout), 32'(e[8]));
            got++;
          end
        end
        if (acc) begin
          q.push_back({1'b0, gb.a} - {1'b0, gb.b} - 9'(gb.bin));
          if (last >= 0) chk("bb_period", 32'(guard - last), 32'(GN + 2));
          last = guard;
        end
        tick;
        if (acc) begin
          gb.a = 8'($urandom);
          gb.b = 8'($urandom);
          gb.bin = 1'($urandom);
        end
      end
      chk("bb_count", 32'(got), 32'd1000);
      done = 1'b1;
    end
  end

  initial begin
    int k;
    rst = 1'b1;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    bus.a = '0;
    bus.b = '0;
    bus.bin = 1'b0;
    tick;
    tick;
    cmp_en = 1'b1;
    chk("rst_in_ready", 32'(bus.in_ready), 32'd0);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_diff", 32'(bus.diff), 32'd0);
    chk("rst_bout", 32'(bus.bout), 32'd0);
    rst = 1'b0;
    #1;
    chk("rel_in_ready", 32'(bus.in_ready), 32'd1);
    tick;

    run_op(8'h05, 8'h03, 1'b0, 8'h02, 1'b0, 1'b0, 1'b0);
    run_op(8'h03, 8'h05, 1'b0, 8'hFE, 1'b1, 1'b0, 1'b0);
    run_op(8'h00, 8'h00, 1'b1, 8'hFF, 1'b1, 1'b0, 1'b0);
    run_op(8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b0, 1'b1);
    run_op(8'h5A, 8'h5A, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0);

    // consumer stall: result held, no new accept
    bus.out_ready = 1'b0;
    run_op(8'h03, 8'h05, 1'b0, 8'hFE, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      chk("hold_valid", 32'(bus.out_valid), 32'd1);
      chk("hold_diff", 32'(bus.diff), 32'hFE);
      chk("hold_bout", 32'(bus.bout), 32'd1);
      chk("hold_in_ready", 32'(bus.in_ready), 32'd0);
      bus.in_valid = 1'b1;
      tick;
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    tick;
    chk("drop_valid", 32'(bus.out_valid), 32'd0);
    chk("drop_in_ready", 32'(bus.in_ready), 32'd1);

    // reset in the middle of RUN
    bus.in_valid = 1'b1;
    bus.a = 8'h33;
    bus.b = 8'h11;
    bus.bin = 1'b0;
    tick;
    bus.in_valid = 1'b0;
    rst = 1'b1;
    tick;
    rst = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(bus.out_valid), 32'd0);
    chk("mid_rst_diff", 32'(bus.diff), 32'd0);
    chk("mid_rst_bout", 32'(bus.bout), 32'd0);
    chk("mid_rst_ready", 32'(bus.in_ready), 32'd1);
    tick;
    tick;
    chk("mid_rst_quiet", 32'(bus.out_valid), 32'd0);
    run_op(8'h10, 8'h01, 1'b0, 8'h0F, 1'b0, 1'b0, 1'b0);

    // random traffic with random consumer stalls
    for (int i = 0; i < 3000; i++) begin
      bus.in_valid = 1'($urandom);
      bus.a = 8'($urandom);
      bus.b = 8'($urandom);
      bus.bin = 1'($urandom);
      bus.out_ready = ($urandom_range(3) != 0);
      tick;
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 8; i++) tick;

    k = 0;
    while (!(g_bb[0].done && g_bb[1].done) && k < 30000) begin
      tick;
      k++;
    end
    chk("bb_done", 32'(g_bb[0].done && g_bb[1].done), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
